fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised successor to the core's single-register fetch path (PC register, PC+4 adder, one F/D register).
- Fetch stage with a decoupled instruction prefetch queue of configurable depth, a request/grant instruction-memory port with fixed 1-cycle response, and redirect/flush from Execute (branch, jal, jalr).
- Sits between instruction memory and Decode; replaces the F/D stall/flush register with a valid/ready queue.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address, equal to current PC.
- imem_gnt  input  1  request accepted this cycle; meaningful only when imem_req=1.
- imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
- imem_rvalid  input  1  response, exactly 1 cycle after each grant.
- redirect_valid  input  1  Execute redirect (taken branch/jump).
- redirect_pc  input  XLEN  redirect target.
- instr_valid  output  1  queue head valid.
- instr  output  32  head instruction.
- instr_pc  output  XLEN  head PC.
- instr_pcplus4  output  XLEN  head PC+4.
- instr_ready  input  1  Decode accepts head (inverse of stallD).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- perf_fetch_cnt  output  32  instructions enqueued (see Optional Feature).
- perf_flush_cnt  output  32  redirects taken (see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge): PC=RESET_PC; queue empty; inflight=0; fifo_count=0; instr_valid=0; imem_req=0 the cycle after reset. instr/instr_pc/instr_pcplus4 don't-care while instr_valid=0. Reset mid-operation discards queue and in-flight response.
- inflight: register set on (imem_req & imem_gnt), cleared otherwise; marks response due next cycle.
- imem_req = !rst_state & !redirect_valid & (fifo_count + inflight < FIFO_DEPTH). Comb. Pop in the same cycle does not add credit, so the queue never overflows.
- imem_addr = PC. On grant: PC <= PC + 4, mod 2^XLEN wrap.
- Response: when imem_rvalid & !redirect_valid, enqueue {imem_rdata, pc_of_request}. The PC of the in-flight request is held in a register captured at grant.
- Latency: grant at cycle t -> data at t+1 -> instr_valid at t+2 if queue was empty. No bypass.
- Dequeue: pop when instr_valid & instr_ready & !redirect_valid. Head order is strict FIFO. Read and write pointers wrap modulo FIFO_DEPTH.
- Simultaneous push+pop: count unchanged. Push with count=FIFO_DEPTH cannot occur by construction. Assertion-level check in the bench.
- Redirect (redirect_valid=1 in cycle t): imem_req=0 in t. At edge: queue cleared (count=0), same-cycle response dropped, pending pop ignored, PC <= {redirect_pc[XLEN-1:2],2'b00}. Fetch resumes at t+1.
- Response arriving with no prior grant is ignored.
- instr_pcplus4 = instr_pc + 4, computed at enqueue and stored.

Optional Feature:
- FETCH_PERF_EN defined:
  - perf_fetch_cnt increments on each enqueue.
  - perf_flush_cnt increments on each cycle with redirect_valid=1.
  - Both 32-bit, wrap at 2^32, cleared by rst.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- Reset then imem_gnt=1 every cycle, imem_rdata = address, instr_ready=1 -> instr_valid first high 2 cycles after first grant. instr_pc sequence 0x0,0x4,0x8,...; instr=instr_pc; instr_pcplus4=instr_pc+4.
- instr_ready=0, grant always -> exactly 4 grants (FIFO_DEPTH=4). fifo_count saturates at 4; imem_req=0 thereafter. Raise instr_ready -> entries 0x0..0xC drained in order; fetch resumes at 0x10.
- Queue holding 3 entries plus one in flight; redirect_valid=1 with redirect_pc=0x100 -> the same-cycle response is dropped. Next cycle fifo_count=0, imem_addr=0x100; first instr_pc after redirect=0x100.
- redirect_pc=0x203 -> next imem_addr=0x200.
- imem_gnt toggling 1,0,1,0 with instr_ready=1 -> no duplicate or missing PCs; instr_pc strictly +4 per accepted instruction.
- FETCH_PERF_EN defined: 10 fetches and 2 redirects -> perf_fetch_cnt=10 (only enqueued, dropped excluded), perf_flush_cnt=2. rst mid-run -> both 0, PC=RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/grant port of the fetch queue unit.
// master = fetch side (issues requests), slave = memory side (grants and returns data one cycle later).
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic [31:0]     imem_rdata;
    logic            imem_rvalid;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rdata, imem_rvalid
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rdata, imem_rvalid
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage with a decoupled prefetch queue, 1-cycle-response imem port and Execute redirect.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_queue_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fetch_queue_unit_if.master            imem,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          instr_valid,
    output logic [31:0]                   instr,
    output logic [XLEN-1:0]               instr_pc,
    output logic [XLEN-1:0]               instr_pcplus4,
    input  logic                          instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [31:0]                   perf_flush_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic            rst_state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] pcp4_mem  [FIFO_DEPTH];

    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_target;
    logic            grant;
    logic            push;
    logic            pop;

    // The in-flight request already owns a slot, so a same-cycle pop never adds credit.
    assign occupancy       = {1'b0, count} + (CW+1)'(inflight);
    assign imem.imem_req   = !rst && !rst_state && !redirect_valid
                             && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem.imem_addr  = pc;
    assign redirect_target = redirect_pc & ~(XLEN'(3));

    assign grant       = imem.imem_req && imem.imem_gnt;
    assign push        = imem.imem_rvalid && inflight && !redirect_valid;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    assign instr         = instr_mem[rd_ptr];
    assign instr_pc      = pc_mem[rd_ptr];
    assign instr_pcplus4 = pcp4_mem[rd_ptr];
    assign fifo_count    = count;

    always_ff @(posedge clk) begin
        rst_state <= rst;
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= grant;
            if (grant)
                req_pc <= pc;
            if (redirect_valid) begin
                pc     <= redirect_target;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (grant)
                    pc <= pc + XLEN'(4);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem.imem_rdata;
            pc_mem[wr_ptr]    <= req_pc;
            pcp4_mem[wr_ptr]  <= req_pc + XLEN'(4);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
            flush_q <= '0;
        end else begin
            if (push)
                fetch_q <= fetch_q + 32'd1;
            if (redirect_valid)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; the memory model answers each grant one cycle later with rdata = address.
module tb_fetch_queue_unit;
    localparam int XLEN = 32;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        instr_ready = 1'b1;
    logic [2:0]  fifo_count;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;

    int checks = 0;
    int errors = 0;
    int grants = 0;

    fetch_queue_unit_if #(.XLEN(XLEN)) bus ();

    fetch_queue_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pcplus4  (instr_pcplus4),
        .instr_ready    (instr_ready),
        .fifo_count     (fifo_count),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request just before the edge, then play the memory response after it.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        #1;
        g = bus.imem_req && bus.imem_gnt;
        a = bus.imem_addr;
        if (bus.imem_rvalid && !redirect_valid && !rst)
            chk("no_overflow", {31'd0, fifo_count == 3'd4}, 32'd0);
        if (g)
            grants++;
        @(posedge clk);
        #1;
        bus.imem_rvalid = g;
        bus.imem_rdata  = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_pc;
        int accepted;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset state and first-fetch latency
        tick();
        tick();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hdead_beef;
        tick();
        chk("stray_rsp_count", 32'(fifo_count), 32'd0);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        tick();
        chk("lat_valid_t1", 32'(instr_valid), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc", instr_pc, 32'(4 * k));
            chk("stream_instr", instr, 32'(4 * k));
            chk("stream_pcp4", instr_pcplus4, 32'(4 * k + 4));
            chk("stream_count", 32'(fifo_count), 32'd1);
            tick();
        end

        // Back-pressure: queue fills, fetching stops, then drains in order
        do_reset();
        instr_ready = 1'b0;
        grants = 0;
        for (int k = 0; k < 8; k++) tick();
        chk("bp_grants", 32'(grants), 32'd4);
        chk("bp_count", 32'(fifo_count), 32'd4);
        chk("bp_req", 32'(bus.imem_req), 32'd0);
        chk("bp_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        chk("drain_req", 32'(bus.imem_req), 32'd1);
        chk("drain_addr", bus.imem_addr, 32'h10);
        chk("drain_head1", instr_pc, 32'h4);
        for (int k = 2; k < 6; k++) begin
            tick();
            chk("drain_valid", 32'(instr_valid), 32'd1);
            chk("drain_pc", instr_pc, 32'(4 * k));
        end

        // Redirect with three queued entries and one response arriving
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("redir_pre_count", 32'(fifo_count), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("redir_req", 32'(bus.imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_count", 32'(fifo_count), 32'd0);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_req_back", 32'(bus.imem_req), 32'd1);
        instr_ready = 1'b1;
        tick();
        tick();
        chk("redir_first_valid", 32'(instr_valid), 32'd1);
        chk("redir_first_pc", instr_pc, 32'h100);
        chk("redir_first_instr", instr, 32'h100);
        chk("redir_first_pcp4", instr_pcplus4, 32'h104);

        // Misaligned redirect target is word-aligned
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("align_addr", bus.imem_addr, 32'h200);
        chk("align_count", 32'(fifo_count), 32'd0);
        tick();
        tick();
        chk("align_pc", instr_pc, 32'h200);

        // Toggling grant: every accepted PC exactly once, in order
        do_reset();
        exp_pc   = 0;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            bus.imem_gnt = i[0];
            #1;
            if (instr_valid) begin
                chk("tog_pc", instr_pc, 32'(exp_pc));
                chk("tog_instr", instr, 32'(exp_pc));
                exp_pc += 4;
                accepted++;
            end
            tick();
        end
        chk("tog_accepted", 32'(accepted), 32'd9);
        chk("tog_last_pc", 32'(exp_pc), 32'd36);
        bus.imem_gnt = 1'b0;
        tick();
        chk("perf_fetch", perf_fetch_cnt, PERF ? 32'd10 : 32'd0);
        chk("perf_flush_pre", perf_flush_cnt, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("perf_flush", perf_flush_cnt, PERF ? 32'd2 : 32'd0);
        chk("perf_fetch_post", perf_fetch_cnt, PERF ? 32'd10 : 32'd0);

        // Reset mid-run clears everything
        bus.imem_gnt = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_pc", bus.imem_addr, 32'h0);
        chk("mid_rst_fetch", perf_fetch_cnt, 32'd0);
        chk("mid_rst_flush", perf_flush_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
